// File: rtl/tlul_pkg.sv
// Shared TL-UL integrity constants and scrubber state encoding.
// Data words travel as {7-bit inverted SECDED ECC, 32-bit data}.
package tlul_pkg;

  localparam int DataMaxWidth  = 32;
  localparam int DataIntgWidth = 7;
  localparam int DataIntgTotW  = DataMaxWidth + DataIntgWidth;

  localparam logic [DataIntgWidth-1:0] IntgInvMask = 7'h2A;

  typedef enum logic [1:0] {
    ScrubIdle = 2'd0,
    ScrubWait = 2'd1,
    ScrubReq  = 2'd2,
    ScrubResp = 2'd3
  } scrub_state_e;

endpackage

// File: rtl/tlul_data_integ_dec.sv
// Inverted SECDED 39/32 data integrity checker.
// data_err_o = {double-bit error, single-bit error}.
module tlul_data_integ_dec
  import tlul_pkg::*;
(
  input  logic [DataIntgTotW-1:0] data_intg_i,
  output logic [1:0]              data_err_o
);

  logic [DataIntgTotW-1:0]  word;
  logic [DataIntgWidth-1:0] syn;

  assign word = data_intg_i ^
                {IntgInvMask, {DataMaxWidth{1'b0}}};

  assign syn[0] = ^(word & 39'h01_2606_BD25);
  assign syn[1] = ^(word & 39'h02_DEBA_8050);
  assign syn[2] = ^(word & 39'h04_413D_89AA);
  assign syn[3] = ^(word & 39'h08_3123_4ED1);
  assign syn[4] = ^(word & 39'h10_C2C1_323B);
  assign syn[5] = ^(word & 39'h20_2DCC_624C);
  assign syn[6] = ^(word & 39'h40_9850_5586);

  assign data_err_o[0] = ^syn;
  assign data_err_o[1] = (|syn) & ~(^syn);

endmodule

// File: rtl/tlul_intg_scrub_ctrl.sv
// Background integrity scrubber: walks all words, one read
// outstanding, and accumulates integrity error statistics.
module tlul_intg_scrub_ctrl
  import tlul_pkg::*;
#(
  parameter int Depth   = 256,
  parameter int AddrW   = $clog2(Depth),
  parameter int PeriodW = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [PeriodW-1:0]      period_i,
  input  logic                    start_i,
  input  logic                    clr_i,
  output logic                    req_o,
  output logic [AddrW-1:0]        addr_o,
  input  logic                    gnt_i,
  input  logic                    rvalid_i,
  input  logic [DataIntgTotW-1:0] rdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             err_cnt_o,
  output logic                    err_valid_o,
  output logic [AddrW-1:0]        err_addr_o,
  output logic                    alert_o
);

  localparam logic [AddrW-1:0]   LastAddr = AddrW'(Depth - 1);
  localparam logic [AddrW-1:0]   AddrOne  = AddrW'(1);
  localparam logic [PeriodW:0]   CntOne   = (PeriodW+1)'(1);

  scrub_state_e state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [PeriodW:0] cnt_q, cnt_d;
  logic             done_d;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      err_cnt_q;
  logic             err_valid_q;
  logic [AddrW-1:0] err_addr_q;
  logic             alert_q;
  logic [1:0]       intg_err;
  logic             word_err;
  logic             last_word;

  tlul_data_integ_dec u_intg_chk (
    .data_intg_i (rdata_i),
    .data_err_o  (intg_err)
  );

  assign last_word = (addr_q == LastAddr);
  assign word_err  = (state_q == ScrubResp) & rvalid_i & (|intg_err);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ScrubIdle: begin
        if (start_i) begin
          state_d = ScrubReq;
          addr_d  = '0;
        end else if (en_i) begin
          state_d = ScrubWait;
          cnt_d   = {1'b0, period_i};
        end
      end
      ScrubWait: begin
        if (start_i || (en_i && cnt_q == '0)) begin
          state_d = ScrubReq;
          addr_d  = '0;
        end else if (!en_i) begin
          state_d = ScrubIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      ScrubReq: begin
        if (gnt_i) state_d = ScrubResp;
      end
      ScrubResp: begin
        if (rvalid_i) begin
          if (last_word) begin
            done_d = 1'b1;
            // Extra count absorbs the cycle in which done_o is shown.
            if (en_i) begin
              state_d = ScrubWait;
              cnt_d   = {1'b0, period_i} + CntOne;
            end else begin
              state_d = ScrubIdle;
            end
          end else begin
            state_d = ScrubReq;
            addr_d  = addr_q + AddrOne;
          end
        end
      end
      default: state_d = ScrubIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ScrubIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= (state_d == ScrubReq) |
                 (state_d == ScrubResp);
    end
  end

  // A clear in the same cycle as an error lands before the error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      alert_q     <= 1'b0;
    end else begin
      alert_q <= word_err;
      if (word_err) begin
        if (clr_i) begin
          err_cnt_q <= 16'd1;
        end else if (err_cnt_q != 16'hFFFF) begin
          err_cnt_q <= err_cnt_q + 16'd1;
        end
        if (clr_i || !err_valid_q) begin
          err_addr_q  <= addr_q;
          err_valid_q <= 1'b1;
        end
      end else if (clr_i) begin
        err_cnt_q   <= '0;
        err_valid_q <= 1'b0;
      end
    end
  end

  assign req_o       = (state_q == ScrubReq);
  assign addr_o      = addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_cnt_o   = err_cnt_q;
  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign alert_o     = alert_q;

endmodule
